fp_minmax_reduce: RTL and testbench

// - Sequential FP32 min/max reduction unit (vfredmin/vfredmax) over recoded (33-bit HardFloat) elements.
// - Sits directly downstream of the recoded-FP comparator. It consumes the comparator's lt/eq/gt and

---
 rtl/fp_minmax_reduce_pkg.sv | 33 +++
 rtl/fp_minmax_reduce_compare.sv | 79 +++++++
 rtl/fp_minmax_reduce.sv | 141 ++++++++++++++
 tb/tb_fp_minmax_reduce.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_minmax_reduce_pkg.sv
// Shared definitions for the FP32 min/max reduction unit.
// Recoded (HardFloat) FP32 layout, 33 bits:
//   [32]    sign
//   [31:23] recoded exponent (9 bits); top three bits 000 = zero, 11x = special
//           (110 = infinity, 111 = NaN)
//   [22:0]  fraction; bit 22 set = quiet NaN
package fp_minmax_reduce_pkg;

    localparam int EXP_WIDTH = 8;
    localparam int SIG_WIDTH = 24;
    localparam int REC_W     = EXP_WIDTH + SIG_WIDTH + 1;

    localparam logic [REC_W-1:0] CANON_NAN_F32 = 33'h0E0400000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    function automatic logic isNaNRec(input logic [REC_W-1:0] x);
        return x[REC_W-2 -: 3] == 3'b111;
    endfunction

    function automatic logic isSigNaNRec(input logic [REC_W-1:0] x);
        return (x[REC_W-2 -: 3] == 3'b111) && !x[SIG_WIDTH-2];
    endfunction

    function automatic logic isZeroRec(input logic [REC_W-1:0] x);
        return x[REC_W-2 -: 3] == 3'b000;
    endfunction

endpackage

// File: rtl/fp_minmax_reduce_compare.sv
// CompareRecFN: combinational comparator for recoded floating-point values.
// Ports:
//   io_a, io_b            recoded operands
//   io_signaling          1 = any NaN operand raises invalid (not just sNaN)
//   io_lt, io_eq, io_gt   ordered relations a<b, a==b, a>b (all 0 when unordered)
//   io_exceptionFlags     {NV,DZ,OF,UF,NX}; only NV is ever produced
module CompareRecFN #(
    parameter int EXP_WIDTH = 8,
    parameter int SIG_WIDTH = 24
) (
    input  logic [EXP_WIDTH+SIG_WIDTH:0] io_a,
    input  logic [EXP_WIDTH+SIG_WIDTH:0] io_b,
    input  logic                         io_signaling,
    output logic                         io_lt,
    output logic                         io_eq,
    output logic                         io_gt,
    output logic [4:0]                   io_exceptionFlags
);

    localparam int W = EXP_WIDTH + SIG_WIDTH + 1;

    logic                 sign_a, sign_b;
    logic [EXP_WIDTH:0]   exp_a, exp_b;
    logic [SIG_WIDTH-2:0] fract_a, fract_b;
    logic                 zero_a, zero_b, spec_a, spec_b;
    logic                 nan_a, nan_b, inf_a, inf_b, snan_a, snan_b;
    logic [SIG_WIDTH-1:0] sig_a, sig_b;
    logic                 ordered, both_infs, both_zeros;
    logic                 eq_exps, lt_mags, eq_mags;
    logic                 ordered_lt, ordered_eq, invalid;

    assign sign_a  = io_a[W-1];
    assign sign_b  = io_b[W-1];
    assign exp_a   = io_a[W-2 -: EXP_WIDTH+1];
    assign exp_b   = io_b[W-2 -: EXP_WIDTH+1];
    assign fract_a = io_a[SIG_WIDTH-2:0];
    assign fract_b = io_b[SIG_WIDTH-2:0];

    assign zero_a = exp_a[EXP_WIDTH -: 3] == 3'b000;
    assign zero_b = exp_b[EXP_WIDTH -: 3] == 3'b000;
    assign spec_a = exp_a[EXP_WIDTH -: 2] == 2'b11;
    assign spec_b = exp_b[EXP_WIDTH -: 2] == 2'b11;
    assign nan_a  = spec_a && exp_a[EXP_WIDTH-2];
    assign nan_b  = spec_b && exp_b[EXP_WIDTH-2];
    assign inf_a  = spec_a && !exp_a[EXP_WIDTH-2];
    assign inf_b  = spec_b && !exp_b[EXP_WIDTH-2];
    assign snan_a = nan_a && !fract_a[SIG_WIDTH-2];
    assign snan_b = nan_b && !fract_b[SIG_WIDTH-2];

    // Hidden bit is explicit so magnitudes compare as {exp, sig}.
    assign sig_a = {!zero_a, fract_a};
    assign sig_b = {!zero_b, fract_b};

    assign ordered    = !nan_a && !nan_b;
    assign both_infs  = inf_a && inf_b;
    assign both_zeros = zero_a && zero_b;

    assign eq_exps = exp_a == exp_b;
    assign lt_mags = (exp_a < exp_b) || (eq_exps && (sig_a < sig_b));
    assign eq_mags = eq_exps && (sig_a == sig_b);

    // Zeros of either sign are equal; infinities of equal sign are equal
    // regardless of the don't-care payload bits.
    assign ordered_lt = !both_zeros &&
                        ((sign_a && !sign_b) ||
                         (!both_infs &&
                          ((sign_a && !lt_mags && !eq_mags) ||
                           (!sign_b && lt_mags))));
    assign ordered_eq = both_zeros ||
                        ((sign_a == sign_b) && (both_infs || eq_mags));

    assign invalid = snan_a || snan_b || (io_signaling && !ordered);

    assign io_lt             = ordered && ordered_lt;
    assign io_eq             = ordered && ordered_eq;
    assign io_gt             = ordered && !ordered_lt && !ordered_eq;
    assign io_exceptionFlags = {invalid, 4'b0000};

endmodule

// File: rtl/fp_minmax_reduce.sv
// fp_minmax_reduce: sequential FP32 min/max reduction over recoded elements.
// Ports:
//   clock, reset                   clock; synchronous active-low reset
//   io_start_*                     start handshake: initial scalar and max/min select
//   io_elem_*                      element stream: data, active mask, last marker
//   io_out_*                       result handshake: recoded result and accrued flags
// Handshake rule: a transfer happens on a rising edge where valid && ready;
// valid holders keep their payload stable until that edge, and ready is a
// pure function of the current FSM state.
module fp_minmax_reduce
    import fp_minmax_reduce_pkg::*;
#(
    parameter int EXP_WIDTH = fp_minmax_reduce_pkg::EXP_WIDTH,
    parameter int SIG_WIDTH = fp_minmax_reduce_pkg::SIG_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_start_valid,
    output logic             io_start_ready,
    input  logic [REC_W-1:0] io_start_bits_init,
    input  logic             io_start_bits_isMax,
    input  logic             io_elem_valid,
    output logic             io_elem_ready,
    input  logic [REC_W-1:0] io_elem_bits_data,
    input  logic             io_elem_bits_mask,
    input  logic             io_elem_bits_last,
    output logic             io_out_valid,
    input  logic             io_out_ready,
    output logic [REC_W-1:0] io_out_bits_result,
    output logic [4:0]       io_out_bits_exceptionFlags
);

    localparam logic [REC_W-1:0] POS_ZERO = '0;
    localparam logic [REC_W-1:0] NEG_ZERO = {1'b1, {(REC_W-1){1'b0}}};

    state_e           state_q, state_d;
    logic [REC_W-1:0] acc_q, acc_d;
    logic [4:0]       flags_q, flags_d;
    logic             is_max_q, is_max_d;

    logic             start_fire, elem_fire, out_fire;
    logic             cmp_lt, cmp_eq, cmp_gt;
    logic [4:0]       cmp_flags;
    logic [REC_W-1:0] acc_upd;

    // Accumulator is never an sNaN, so the comparator's invalid flag only
    // reflects a signaling NaN on the incoming element.
    CompareRecFN #(
        .EXP_WIDTH(EXP_WIDTH),
        .SIG_WIDTH(SIG_WIDTH)
    ) u_cmp (
        .io_a              (acc_q),
        .io_b              (io_elem_bits_data),
        .io_signaling      (1'b0),
        .io_lt             (cmp_lt),
        .io_eq             (cmp_eq),
        .io_gt             (cmp_gt),
        .io_exceptionFlags (cmp_flags)
    );

    assign io_start_ready = (state_q == IDLE);
    assign io_elem_ready  = (state_q == ACCUM);
    assign io_out_valid   = (state_q == DONE);

    assign start_fire = io_start_valid && io_start_ready;
    assign elem_fire  = io_elem_valid && io_elem_ready;
    assign out_fire   = io_out_valid && io_out_ready;

    assign io_out_bits_result         = acc_q;
    assign io_out_bits_exceptionFlags = flags_q;

    // Candidate accumulator for an active element. NaN elements never win, so
    // an all-NaN reduction stays at the canonical NaN loaded at start.
    always_comb begin
        acc_upd = acc_q;
        if (isNaNRec(io_elem_bits_data)) begin
            acc_upd = acc_q;
        end else if (isNaNRec(acc_q)) begin
            acc_upd = io_elem_bits_data;
        end else if (cmp_lt) begin
            acc_upd = is_max_q ? io_elem_bits_data : acc_q;
        end else if (cmp_gt) begin
            acc_upd = is_max_q ? acc_q : io_elem_bits_data;
        end else if (cmp_eq && isZeroRec(acc_q) && isZeroRec(io_elem_bits_data) &&
                     (acc_q[REC_W-1] != io_elem_bits_data[REC_W-1])) begin
            // Opposite-signed zeros: max prefers +0, min prefers -0.
            acc_upd = is_max_q ? POS_ZERO : NEG_ZERO;
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        flags_d  = flags_q;
        is_max_d = is_max_q;
        case (state_q)
            IDLE: begin
                if (start_fire) begin
                    acc_d    = isNaNRec(io_start_bits_init) ? CANON_NAN_F32 : io_start_bits_init;
                    flags_d  = {isSigNaNRec(io_start_bits_init), 4'b0000};
                    is_max_d = io_start_bits_isMax;
                    state_d  = ACCUM;
                end
            end
            ACCUM: begin
                if (elem_fire) begin
                    if (io_elem_bits_mask) begin
                        acc_d   = acc_upd;
                        flags_d = flags_q | cmp_flags;
                    end
                    if (io_elem_bits_last) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_fire) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            flags_q  <= '0;
            is_max_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            flags_q  <= flags_d;
            is_max_q <= is_max_d;
        end
    end

endmodule

// File: tb/tb_fp_minmax_reduce.sv
// Directed bench for fp_minmax_reduce: stimulus driven on the falling edge,
// outputs sampled on the falling edge, transfers occur on the rising edge.
module tb_fp_minmax_reduce;

    localparam logic [32:0] P_ONE   = 33'h080000000;
    localparam logic [32:0] P_TWO   = 33'h080800000;
    localparam logic [32:0] N_THREE = 33'h180C00000;
    localparam logic [32:0] P_ZERO  = 33'h000000000;
    localparam logic [32:0] N_ZERO  = 33'h100000000;
    localparam logic [32:0] S_NAN   = 33'h0E0000001;
    localparam logic [32:0] Q_NAN   = 33'h0E0400001;
    localparam logic [32:0] C_NAN   = 33'h0E0400000;

    logic        clock;
    logic        reset;
    logic        io_start_valid;
    logic        io_start_ready;
    logic [32:0] io_start_bits_init;
    logic        io_start_bits_isMax;
    logic        io_elem_valid;
    logic        io_elem_ready;
    logic [32:0] io_elem_bits_data;
    logic        io_elem_bits_mask;
    logic        io_elem_bits_last;
    logic        io_out_valid;
    logic        io_out_ready;
    logic [32:0] io_out_bits_result;
    logic [4:0]  io_out_bits_exceptionFlags;

    int checks = 0;
    int errors = 0;

    logic [32:0] elems [4];
    logic        masks [4];

    fp_minmax_reduce dut (
        .clock                      (clock),
        .reset                      (reset),
        .io_start_valid             (io_start_valid),
        .io_start_ready             (io_start_ready),
        .io_start_bits_init         (io_start_bits_init),
        .io_start_bits_isMax        (io_start_bits_isMax),
        .io_elem_valid              (io_elem_valid),
        .io_elem_ready              (io_elem_ready),
        .io_elem_bits_data          (io_elem_bits_data),
        .io_elem_bits_mask          (io_elem_bits_mask),
        .io_elem_bits_last          (io_elem_bits_last),
        .io_out_valid               (io_out_valid),
        .io_out_ready               (io_out_ready),
        .io_out_bits_result         (io_out_bits_result),
        .io_out_bits_exceptionFlags (io_out_bits_exceptionFlags)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

    // One full reduction: start, stream n elements (last on the final one),
    // hold out_ready low for hold cycles, then accept the result.
    task automatic run_reduction(input string name, input logic [32:0] init,
                                 input logic is_max, input int n,
                                 input logic [32:0] exp_res, input logic [4:0] exp_flags,
                                 input int hold);
        @(negedge clock);
        io_start_valid      = 1'b1;
        io_start_bits_init  = init;
        io_start_bits_isMax = is_max;
        checks++;
        if (io_start_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s start_ready: got %b expected 1", name, io_start_ready);
        end
        @(negedge clock);
        io_start_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            io_elem_valid     = 1'b1;
            io_elem_bits_data = elems[i];
            io_elem_bits_mask = masks[i];
            io_elem_bits_last = (i == n - 1);
            checks++;
            if (io_elem_ready !== 1'b1) begin
                errors++;
                $display("FAIL %s elem_ready[%0d]: got %b expected 1", name, i, io_elem_ready);
            end
            @(negedge clock);
        end
        io_elem_valid     = 1'b0;
        io_elem_bits_last = 1'b0;
        // One cycle after the last-element transfer the result must be offered.
        checks++;
        if (io_out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s out_valid latency: got %b expected 1", name, io_out_valid);
        end
        checks++;
        if (io_elem_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s elem_ready in DONE: got %b expected 0", name, io_elem_ready);
        end
        for (int h = 0; h < hold; h++) begin
            checks++;
            if (io_out_bits_result !== exp_res || io_out_bits_exceptionFlags !== exp_flags ||
                io_out_valid !== 1'b1 || io_start_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s hold[%0d]: got res=%h flags=%h ov=%b sr=%b expected res=%h flags=%h ov=1 sr=0",
                         name, h, io_out_bits_result, io_out_bits_exceptionFlags,
                         io_out_valid, io_start_ready, exp_res, exp_flags);
            end
            @(negedge clock);
        end
        checks++;
        if (io_out_bits_result !== exp_res) begin
            errors++;
            $display("FAIL %s result: got %h expected %h", name, io_out_bits_result, exp_res);
        end
        checks++;
        if (io_out_bits_exceptionFlags !== exp_flags) begin
            errors++;
            $display("FAIL %s flags: got %h expected %h", name, io_out_bits_exceptionFlags, exp_flags);
        end
        io_out_ready = 1'b1;
        @(negedge clock);
        io_out_ready = 1'b0;
        checks++;
        if (io_out_valid !== 1'b0 || io_start_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s after out fire: got ov=%b sr=%b expected ov=0 sr=1",
                     name, io_out_valid, io_start_ready);
        end
    endtask

    task automatic test_reset;
        reset               = 1'b0;
        io_start_valid      = 1'b0;
        io_start_bits_init  = '0;
        io_start_bits_isMax = 1'b0;
        io_elem_valid       = 1'b0;
        io_elem_bits_data   = '0;
        io_elem_bits_mask   = 1'b0;
        io_elem_bits_last   = 1'b0;
        io_out_ready        = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if (io_start_ready !== 1'b1 || io_elem_ready !== 1'b0 || io_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset handshake: got sr=%b er=%b ov=%b expected 1 0 0",
                     io_start_ready, io_elem_ready, io_out_valid);
        end
        checks++;
        if (io_out_bits_result !== 33'h0 || io_out_bits_exceptionFlags !== 5'h00) begin
            errors++;
            $display("FAIL reset state: got res=%h flags=%h expected 0 0",
                     io_out_bits_result, io_out_bits_exceptionFlags);
        end
    endtask

    task automatic test_max_basic;
        elems[0] = P_TWO;   masks[0] = 1'b1;
        elems[1] = N_THREE; masks[1] = 1'b1;
        run_reduction("max_basic", P_ONE, 1'b1, 2, P_TWO, 5'h00, 0);
    endtask

    task automatic test_min_basic;
        elems[0] = P_TWO;   masks[0] = 1'b1;
        elems[1] = N_THREE; masks[1] = 1'b1;
        run_reduction("min_basic", P_ONE, 1'b0, 2, N_THREE, 5'h00, 0);
    endtask

    task automatic test_signed_zero;
        elems[0] = N_ZERO; masks[0] = 1'b1;
        run_reduction("min_zero", P_ZERO, 1'b0, 1, N_ZERO, 5'h00, 0);
        elems[0] = P_ZERO; masks[0] = 1'b1;
        run_reduction("max_zero", N_ZERO, 1'b1, 1, P_ZERO, 5'h00, 0);
    endtask

    task automatic test_snan_elem;
        elems[0] = S_NAN; masks[0] = 1'b1;
        run_reduction("snan_elem", P_ONE, 1'b1, 1, P_ONE, 5'h10, 0);
    endtask

    task automatic test_nan_masked_hold;
        // Masked elements must not move the accumulator, even a sNaN one.
        elems[0] = P_TWO; masks[0] = 1'b0;
        elems[1] = S_NAN; masks[1] = 1'b0;
        run_reduction("nan_masked_hold", Q_NAN, 1'b1, 2, C_NAN, 5'h00, 3);
    endtask

    task automatic test_reset_mid_accum;
        @(negedge clock);
        io_start_valid      = 1'b1;
        io_start_bits_init  = P_ONE;
        io_start_bits_isMax = 1'b1;
        @(negedge clock);
        io_start_valid    = 1'b0;
        io_elem_valid     = 1'b1;
        io_elem_bits_data = S_NAN;
        io_elem_bits_mask = 1'b1;
        io_elem_bits_last = 1'b0;
        @(negedge clock);
        io_elem_valid = 1'b0;
        reset         = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        checks++;
        if (io_start_ready !== 1'b1 || io_out_valid !== 1'b0 || io_elem_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset handshake: got sr=%b ov=%b er=%b expected 1 0 0",
                     io_start_ready, io_out_valid, io_elem_ready);
        end
        checks++;
        if (io_out_bits_result !== 33'h0 || io_out_bits_exceptionFlags !== 5'h00) begin
            errors++;
            $display("FAIL mid_reset state: got res=%h flags=%h expected 0 0",
                     io_out_bits_result, io_out_bits_exceptionFlags);
        end
        elems[0] = P_TWO; masks[0] = 1'b1;
        run_reduction("after_reset", P_ONE, 1'b1, 1, P_TWO, 5'h00, 0);
    endtask

    task automatic test_back_to_back;
        // Mixed masks and an sNaN init: init sNaN -> canonical NaN with NV,
        // first ordered element replaces the NaN, masked -3.0 is ignored.
        elems[0] = P_ONE;   masks[0] = 1'b1;
        elems[1] = N_THREE; masks[1] = 1'b0;
        elems[2] = P_TWO;   masks[2] = 1'b1;
        elems[3] = N_ZERO;  masks[3] = 1'b1;
        run_reduction("b2b_min", S_NAN, 1'b0, 4, N_ZERO, 5'h10, 0);
        run_reduction("b2b_max", S_NAN, 1'b1, 4, P_TWO, 5'h10, 0);
    endtask

    initial begin
        test_reset();
        test_max_basic();
        test_min_basic();
        test_signed_zero();
        test_snan_elem();
        test_nan_masked_hold();
        test_reset_mid_accum();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
